// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, 33-cycle latency.
// Define DIV_SPECIAL_FAST_EN to retire divide-by-zero and signed overflow in 1 cycle.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            aclk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] din1,
    input  logic [XLEN-1:0] din2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] dout
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] dout_q, dout_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            rem_op_q, rem_op_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic            accept;
    logic            signed_op;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   r_shift;
    logic            step_ok;
    logic [XLEN-1:0] q_res, r_res;

    always_comb begin
        accept    = (state_q == IDLE) && start && func[2];
        signed_op = ~func[0];
        abs1      = (signed_op && din1[XLEN-1]) ? -din1 : din1;
        abs2      = (signed_op && din2[XLEN-1]) ? -din2 : din2;
        div_zero  = (din2 == '0);
        ovf       = signed_op && (din1 == MIN_NEG) && (din2 == '1);

        r_shift   = {rem_q, quo_q[XLEN-1]};
        step_ok   = (r_shift >= {1'b0, divisor_q});

        // Mandated special-case results override the arithmetic outcome.
        q_res = div_zero_q ? '1 : ovf_q ? MIN_NEG : (neg_q_q ? -quo_q : quo_q);
        r_res = ovf_q ? '0 : (neg_r_q ? -rem_q : rem_q);
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        dout_d     = dout_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        rem_op_d   = rem_op_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d      = '0;
                    rem_d      = '0;
                    quo_d      = abs1;
                    divisor_d  = abs2;
                    neg_q_d    = signed_op && (din1[XLEN-1] ^ din2[XLEN-1]);
                    neg_r_d    = signed_op && din1[XLEN-1];
                    rem_op_d   = func[1];
                    div_zero_d = div_zero;
                    ovf_d      = ovf;
`ifdef DIV_SPECIAL_FAST_EN
                    if (div_zero || ovf) begin
                        // Preload the dividend so FIX sees the divide-by-zero remainder.
                        rem_d   = div_zero ? abs1 : '0;
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d    = CALC;
`endif
                end
            end
            CALC: begin
                rem_d = step_ok ? XLEN'(r_shift - {1'b0, divisor_q}) : r_shift[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], step_ok};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                dout_d  = rem_op_q ? r_res : q_res;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            dout_q     <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            rem_op_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            dout_q     <= dout_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            rem_op_q   <= rem_op_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Busy stays high through the done cycle, after the FSM is already back in IDLE.
    assign busy = (state_q != IDLE) || done_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized operations
// compared against an arithmetic reference model (honours DIV_SPECIAL_FAST_EN latency).
module tb_div_unit;

    logic        aclk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func;
    logic [31:0] din1, din2;
    logic        busy, done;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    div_unit #(.XLEN(32)) dut (
        .aclk  (aclk),
        .rst   (rst),
        .start (start),
        .func  (func),
        .din1  (din1),
        .din2  (din2),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int  sa, sb;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            F_DIV:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            F_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SPECIAL_FAST_EN
        if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    // Wait (bounded) for done after the accepting edge; returns edges counted.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge aclk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat;
        @(negedge aclk);
        start = 1'b1; func = f; din1 = a; din2 = b;
        @(posedge aclk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_latency(f, a, b)));
        check({tag, "_dout"}, dout, model(f, a, b));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
    endtask

    initial begin
        int lat;
        logic [2:0]  f;
        logic [31:0] a, b, held;

        rst = 1'b1; start = 1'b0; func = 3'b000; din1 = '0; din2 = '0;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", dout, 32'd0);
        @(negedge aclk); rst = 1'b0;

        do_op("divu_100_7",  F_DIVU, 32'd100, 32'd7);
        do_op("remu_100_7",  F_REMU, 32'd100, 32'd7);
        do_op("div_m7_2",    F_DIV,  32'hFFFF_FFF9, 32'd2);
        do_op("rem_m7_2",    F_REM,  32'hFFFF_FFF9, 32'd2);
        do_op("div_7_m2",    F_DIV,  32'd7, 32'hFFFF_FFFE);
        do_op("rem_7_m2",    F_REM,  32'd7, 32'hFFFF_FFFE);
        do_op("div_5_0",     F_DIV,  32'd5, 32'd0);
        do_op("remu_1234_0", F_REMU, 32'h1234, 32'd0);
        do_op("rem_neg_0",   F_REM,  32'h8000_0000, 32'd0);
        do_op("div_ovf",     F_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_ovf",     F_REM,  32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_ovfops", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

        // Start during CALC is ignored; dout holds the previous result meanwhile.
        held = dout;
        @(negedge aclk);
        start = 1'b1; func = F_DIVU; din1 = 32'd1000; din2 = 32'd7;
        @(negedge aclk);
        start = 1'b0;
        repeat (5) @(negedge aclk);
        start = 1'b1; func = F_DIV; din1 = 32'd5; din2 = 32'd5;
        @(negedge aclk);
        start = 1'b0;
        check("calc_dout_hold", dout, held);
        wait_done(lat);
        check("ignore_start_dout", dout, 32'd142);

        // Rejected func code: no busy, no done.
        @(negedge aclk);
        start = 1'b1; func = 3'b000; din1 = 32'd9; din2 = 32'd3;
        @(negedge aclk);
        start = 1'b0;
        check("bad_func_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge aclk);
        #1;
        check("bad_func_done", 32'(done), 32'd0);

        // Reset in the middle of CALC.
        @(negedge aclk);
        start = 1'b1; func = F_DIVU; din1 = 32'hDEAD_BEEF; din2 = 32'd3;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_dout", dout, 32'd0);
        @(negedge aclk); rst = 1'b0;
        do_op("divu_9_3", F_DIVU, 32'd9, 32'd3);

        // Randomized back-to-back traffic (each new start lands in the done cycle).
        for (int i = 0; i < 150; i++) begin
            f = 3'b100 | 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), f, a, b);
        end

        @(posedge aclk); #1;
        check("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
